// File: rtl/telemetry_frame_check_if.sv
// Frame stream bundle for telemetry_frame_check: unpacker input strobe and
// FWFT output handshake toward the register/DMA consumer.
// master = the checker (drives m_*), slave = unpacker/consumer side.
interface telemetry_frame_check_if #(
  parameter int g_data_width = 11
) ();
  localparam int c_w = 8 * g_data_width;

  logic [c_w-1:0] data_in;
  logic           valid_in;
  logic [c_w-1:0] m_data;
  logic           m_err;
  logic           m_valid;
  logic           m_ready;

  modport master (
    input  data_in, valid_in, m_ready,
    output m_data, m_err, m_valid
  );

  modport slave (
    output data_in, valid_in, m_ready,
    input  m_data, m_err, m_valid
  );
endinterface

// File: rtl/telemetry_frame_check.sv
// telemetry_frame_check: checksum + sequence check of 11-byte telemetry frames,
// buffered in a small FWFT FIFO. The unpacker cannot be stalled, so a frame that
// finds the FIFO full is dropped and counted.
// Optional build macro TELEM_CHECK_DROP_BAD_EN: bad-checksum frames are counted
// but never stored, and m_err is tied low.
//
// Sequence tracker states:
//   state       | meaning
//   ST_UNLOCKED | no good frame seen yet (or lost lock); next good frame locks
//   ST_LOCKED   | expected seq valid; 4 consecutive bad-checksum frames unlock
module telemetry_frame_check #(
  parameter int g_data_width = 11,
  parameter int g_depth      = 8,
  parameter int g_cnt_width  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  telemetry_frame_check_if.master bus,
  output logic                   locked,
  output logic [g_cnt_width-1:0] err_csum_cnt,
  output logic [g_cnt_width-1:0] err_seq_cnt,
  output logic [g_cnt_width-1:0] ovf_cnt
);
  localparam int c_w  = 8 * g_data_width;
  localparam int c_aw = $clog2(g_depth);

  if (g_data_width != 11) begin : g_bad_width
    $fatal(1, "telemetry_frame_check: only 11-byte frames are supported");
  end
  if ((g_depth < 2) || (g_depth > 64) || ((g_depth & (g_depth - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "telemetry_frame_check: g_depth must be a power of 2 in 2..64");
  end

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

  logic [7:0]     w_sum;
  logic           r_s1_valid;
  logic [c_w-1:0] r_s1_data;
  logic           r_s1_csum_ok;
  logic [7:0]     w_s1_seq;

  logic [c_w-1:0] r_mem [g_depth];
  logic [c_aw:0]  r_wr_ptr, r_rd_ptr;
  logic           w_empty, w_full, w_pop, w_wr_req, w_wr, w_ovf, w_err_bit;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_expected, w_expected_nxt;
  logic [1:0]     r_bad_tmr, w_bad_tmr_nxt;
  logic           w_seq_err;

  function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] v,
                                                      input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Byte sum of the incoming frame; a valid frame sums to zero mod 256.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < g_data_width; k++) w_sum = w_sum + bus.data_in[8*k +: 8];
  end

  // Stage 1: capture frame and its checksum verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_csum_ok <= 1'b0;
    end else begin
      r_s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        r_s1_data    <= bus.data_in;
        r_s1_csum_ok <= (w_sum == 8'd0);
      end
    end
  end

  assign w_s1_seq = r_s1_data[7:0];

`ifdef TELEM_CHECK_DROP_BAD_EN
  assign w_wr_req  = r_s1_valid & r_s1_csum_ok;
  assign w_err_bit = 1'b0;
`else
  assign w_wr_req  = r_s1_valid;
  assign w_err_bit = ~r_s1_csum_ok;
`endif

  // Extra pointer MSB distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_pop   = ~w_empty & bus.m_ready;
  // A full FIFO still takes the frame when the head leaves in the same cycle.
  assign w_wr    = w_wr_req & (~w_full | w_pop);
  assign w_ovf   = w_wr_req & ~w_wr;

  // Frame storage; pointers carry the reset so storage needs none.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[c_aw-1:0]] <= r_s1_data;
  end

`ifdef TELEM_CHECK_DROP_BAD_EN
  assign bus.m_err = 1'b0;
`else
  logic [g_depth-1:0] r_mem_err;

  // Per-entry bad-checksum flag travelling with the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_mem_err <= '0;
    else if (w_wr) r_mem_err[r_wr_ptr[c_aw-1:0]] <= w_err_bit;
  end

  assign bus.m_err = ~w_empty & r_mem_err[r_rd_ptr[c_aw-1:0]];
`endif

  // FIFO read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign bus.m_valid = ~w_empty;
  assign bus.m_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

  // Sequence tracker state register; r_bad_tmr counts down the bad-frame tolerance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOCKED;
      r_expected <= 8'd0;
      r_bad_tmr  <= 2'd3;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
      r_bad_tmr  <= w_bad_tmr_nxt;
    end
  end

  // Sequence tracker next state; bad-checksum frames only advance the unlock timer.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_bad_tmr_nxt  = r_bad_tmr;
    w_seq_err      = 1'b0;
    if (r_s1_valid) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (r_s1_csum_ok) begin
            w_state_nxt    = ST_LOCKED;
            w_expected_nxt = w_s1_seq + 8'd1;
            w_bad_tmr_nxt  = 2'd3;
          end
        end
        ST_LOCKED: begin
          if (r_s1_csum_ok) begin
            w_seq_err      = (w_s1_seq != r_expected);
            w_expected_nxt = w_s1_seq + 8'd1;
            w_bad_tmr_nxt  = 2'd3;
          end else if (r_bad_tmr == 2'd0) begin
            w_state_nxt = ST_UNLOCKED;
          end else begin
            w_bad_tmr_nxt = r_bad_tmr - 2'd1;
          end
        end
        default: w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  assign locked = (r_state == ST_LOCKED);

  // Saturating status counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_csum_cnt <= '0;
      err_seq_cnt  <= '0;
      ovf_cnt      <= '0;
    end else begin
      err_csum_cnt <= sat_inc(err_csum_cnt, r_s1_valid & ~r_s1_csum_ok);
      err_seq_cnt  <= sat_inc(err_seq_cnt, w_seq_err);
      ovf_cnt      <= sat_inc(ovf_cnt, w_ovf);
    end
  end
endmodule

// File: tb/tb_telemetry_frame_check.sv
// Bench for telemetry_frame_check: queue-based reference model checked every
// cycle, plus hand-computed expectations at the scenario boundaries.
module tb_telemetry_frame_check;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked;
  logic [15:0] err_csum_cnt, err_seq_cnt, ovf_cnt;

  always #5 clk = ~clk;

  telemetry_frame_check_if #(.g_data_width(11)) bus ();

  telemetry_frame_check #(
    .g_data_width(11), .g_depth(DEPTH), .g_cnt_width(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .locked(locked),
    .err_csum_cnt(err_csum_cnt), .err_seq_cnt(err_seq_cnt), .ovf_cnt(ovf_cnt)
  );

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int err_pops = 0;

`ifdef TELEM_CHECK_DROP_BAD_EN
  localparam bit DROP_BAD = 1'b1;
`else
  localparam bit DROP_BAD = 1'b0;
`endif

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Frame whose bytes sum to 0 mod 256 unless bad is set (byte 10 corrupted).
  function automatic logic [87:0] mk(input logic [7:0] seq, input bit bad);
    logic [87:0] f;
    logic [7:0]  s, b;
    f = '0;
    f[7:0] = seq;
    s = seq;
    for (int k = 1; k < 10; k++) begin
      b = seq * 8'd7 + 8'(k * 29) + 8'h5A;
      f[8*k +: 8] = b;
      s = s + b;
    end
    f[87:80] = 8'd0 - s;
    if (bad) f[87:80] = f[87:80] ^ 8'h01;
    return f;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {logic [87:0] data; logic err;} ent_t;
  ent_t        mq[$];
  int          m_csum, m_seqe, m_ovf, m_exp, m_badrun;
  bit          m_locked;
  bit          p_valid;
  logic [87:0] p_data;

  always @(posedge clk or negedge rst_n) begin : model
    int  sum, seq;
    bit  good, pop, acc;
    if (!rst_n) begin
      mq.delete();
      m_csum = 0; m_seqe = 0; m_ovf = 0; m_exp = 0; m_badrun = 0;
      m_locked = 0; p_valid = 0; p_data = '0;
    end else begin
      pop = (mq.size() != 0) && bus.m_ready;
      acc = 0;
      if (p_valid) begin
        sum = 0;
        for (int k = 0; k < 11; k++) sum += int'(p_data[8*k +: 8]);
        good = (sum % 256) == 0;
        seq  = int'(p_data[7:0]);
        if (!good) begin
          m_csum++;
          if (m_locked) begin
            m_badrun++;
            if (m_badrun == 4) begin m_locked = 0; m_badrun = 0; end
          end
        end else begin
          if (m_locked && seq != m_exp) m_seqe++;
          m_locked = 1;
          m_exp = (seq + 1) % 256;
          m_badrun = 0;
        end
        if (good || !DROP_BAD) begin
          if (mq.size() < DEPTH || pop) acc = 1;
          else m_ovf++;
        end
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{data: p_data, err: !good});
      p_valid = bus.valid_in;
      p_data  = bus.data_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_valid", 88'(bus.m_valid), 88'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_data", bus.m_data, mq[0].data);
      chk("m_err", 88'(bus.m_err), 88'(mq[0].err));
    end
    chk("locked", 88'(locked), 88'(m_locked));
    chk("err_csum_cnt", 88'(err_csum_cnt), 88'(m_csum));
    chk("err_seq_cnt", 88'(err_seq_cnt), 88'(m_seqe));
    chk("ovf_cnt", 88'(ovf_cnt), 88'(m_ovf));
    if (rst_n && bus.m_valid && bus.m_ready) begin
      pops++;
      if (bus.m_err) err_pops++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [87:0] d);
    bus.data_in  = d;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  localparam logic [87:0] F5 = 88'hFB_000000000000000000_05;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0, e0;
    bus.data_in = '0; bus.valid_in = 1'b0; bus.m_ready = 1'b0;
    idle(2);
    @(negedge clk);
    chk("rst_m_valid", 88'(bus.m_valid), 88'd0);
    chk("rst_locked", 88'(locked), 88'd0);
    chk("rst_cnts", 88'({err_csum_cnt, err_seq_cnt, ovf_cnt}), 88'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: three good frames, first-frame latency
    bus.m_ready = 1'b1;
    bus.data_in = F5; bus.valid_in = 1'b1;
    @(posedge clk); #1; bus.valid_in = 1'b0;
    @(negedge clk);
    chk("lat_n1_m_valid", 88'(bus.m_valid), 88'd0);
    @(negedge clk);
    chk("lat_n2_m_valid", 88'(bus.m_valid), 88'd1);
    chk("lat_n2_m_data", bus.m_data, F5);
    chk("lat_n2_locked", 88'(locked), 88'd1);
    @(posedge clk); #1;
    send(mk(8'h06, 0));
    send(mk(8'h07, 0));
    idle(4);
    chk("t1_pops", 88'(pops), 88'd3);
    chk("t1_cnts", 88'({err_csum_cnt, err_seq_cnt, ovf_cnt}), 88'd0);
    chk("t1_m_valid", 88'(bus.m_valid), 88'd0);

    // 2: gap in sequence
    send(mk(8'h0A, 0)); idle(3);
    chk("t2_seq_err", 88'(err_seq_cnt), 88'd1);
    send(mk(8'h0B, 0)); idle(3);
    chk("t2_seq_cont", 88'(err_seq_cnt), 88'd1);

    // 3: corrupted checksum
    e0 = err_pops;
    send(mk(8'h0C, 1)); idle(3);
    chk("t3_csum", 88'(err_csum_cnt), 88'd1);
    chk("t3_err_pops", 88'(err_pops - e0), DROP_BAD ? 88'd0 : 88'd1);
    send(mk(8'h0C, 0)); idle(3);
    chk("t3_exp_kept", 88'(err_seq_cnt), 88'd1);

    // 4: overflow with consumer stalled
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(mk(8'(8'h0D + i), 0));
    idle(3);
    chk("t4_ovf", 88'(ovf_cnt), 88'd2);
    chk("t4_held", 88'(bus.m_valid), 88'd1);
    chk("t4_head", bus.m_data, mk(8'h0D, 0));
    p0 = pops;
    bus.m_ready = 1'b1;
    idle(12);
    chk("t4_pops", 88'(pops - p0), 88'd8);
    chk("t4_seq", 88'(err_seq_cnt), 88'd1);

    // 5: full FIFO, write coincides with pop
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(mk(8'(8'h17 + i), 0));
    idle(3);
    bus.data_in = mk(8'h1F, 0); bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    idle(2);
    chk("t5_ovf", 88'(ovf_cnt), 88'd2);
    chk("t5_head", bus.m_data, mk(8'h18, 0));
    p0 = pops;
    bus.m_ready = 1'b1;
    idle(12);
    chk("t5_pops", 88'(pops - p0), 88'd8);

    // 6: wrap, loss of lock, async reset
    send(mk(8'hFF, 0)); send(mk(8'h00, 0)); idle(3);
    chk("t6_wrap", 88'(err_seq_cnt), 88'd2);
    for (int i = 0; i < 3; i++) send(mk(8'h01, 1));
    idle(3);
    chk("t6_locked3", 88'(locked), 88'd1);
    send(mk(8'h01, 1)); idle(3);
    chk("t6_locked4", 88'(locked), 88'd0);
    chk("t6_csum", 88'(err_csum_cnt), 88'd5);
    bus.m_ready = 1'b0;
    send(mk(8'h10, 0)); send(mk(8'h11, 0)); send(mk(8'h12, 0));
    bus.data_in = mk(8'h13, 0); bus.valid_in = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", 88'(bus.m_valid), 88'd0);
    chk("t6_rst_locked", 88'(locked), 88'd0);
    chk("t6_rst_cnts", 88'({err_csum_cnt, err_seq_cnt, ovf_cnt}), 88'd0);
    @(posedge clk); #1; bus.valid_in = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    bus.m_ready = 1'b1;
    send(mk(8'h40, 0)); idle(4);
    chk("t6_relock", 88'(locked), 88'd1);
    chk("t6_relock_seq", 88'(err_seq_cnt), 88'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
